sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Initiator-side controller for the board's asynchronous 16-bit SRAM, which has active-low CE/UB/LB/OE/WE, a 20-bit address and a bidirectional data bus.
- Turns a single-request user handshake into correctly sequenced SRAM read and write cycles, with a configurable wait-state count.
- Sits between datapath/CPU logic and the top-level SRAM pins; in simulation it drives the bench SRAM model directly.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width (two byte lanes; fixed at 16)
WAIT_CYCLES, 1, extra cycles an access is held beyond the first (>=0)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
req  in  1  access request; accepted on a Clk edge where req&ready
we  in  1  1=write, 0=read; sampled on accept
addr  in  ADDR_W  word address; sampled on accept
wdata  in  16  write data; sampled on accept
be  in  2  byte enables [1]=upper, [0]=lower; sampled on accept
ready  out  1  controller idle; can accept req this cycle
rdata  out  16  read data, registered
rvalid  out  1  one-cycle pulse; rdata valid
wdone  out  1  one-cycle pulse; write finished
SRAM_ADDR  out  ADDR_W  SRAM address pins
SRAM_DQ  inout  16  SRAM data bus
SRAM_CE_N  out  1  chip enable, active-low
SRAM_UB_N  out  1  upper byte enable, active-low
SRAM_LB_N  out  1  lower byte enable, active-low
SRAM_OE_N  out  1  output enable, active-low
SRAM_WE_N  out  1  write enable, active-low

Behaviour:
- All SRAM control signals come from registers; no combinational path from req to the pins.
- Reset (async, immediate):
  - state=IDLE, ready=1, rvalid=0, wdone=0, rdata=0, SRAM_ADDR=0.
  - CE_N/UB_N/LB_N/OE_N/WE_N all =1, SRAM_DQ=Z.
- States: IDLE, READ, WRITE, WREC.
- IDLE:
  - ready=1; all _N outputs =1; DQ=Z.
  - On req: latch we/addr/wdata/be, load counter=WAIT_CYCLES, go to WRITE if we else READ.
- READ (WAIT_CYCLES+1 cycles):
  - CE_N=0, OE_N=0, WE_N=1, UB_N=~be[1], LB_N=~be[0], DQ=Z.
  - At the final edge, capture SRAM_DQ into rdata; bytes with be=0 are forced to 8'h00.
  - Go to IDLE with rvalid=1 for that one IDLE cycle.
- WRITE (WAIT_CYCLES+1 cycles):
  - CE_N=0, WE_N=0, OE_N=1, UB_N/LB_N from be; DQ driven with latched wdata.
  - Then go to WREC.
- WREC (1 cycle):
  - CE_N=1, WE_N=1, UB_N=LB_N=1; DQ still driven for data hold; address held.
  - Then go to IDLE with wdone=1 for one cycle.
- Latency, with accept at edge k:
  - Read: rvalid high in cycle after edge k+WAIT_CYCLES+1.
  - Write: wdone high in cycle after edge k+WAIT_CYCLES+2.
- Back-to-back: a req may be accepted in the same IDLE cycle in which rvalid or wdone is high.
- req while ready=0 is ignored; the user must hold req until accepted.
- be=2'b00: the access runs its full timing with UB_N=LB_N=1, so nothing is written; rdata=0 with rvalid pulse.
- OE_N and WE_N are never both 0.
- The DQ output-enable is asserted only in WRITE/WREC, so no bus contention with the SRAM read drive.
- SRAM_ADDR changes only on an accept edge, and holds through the whole access including WREC.
- Reset mid-access: cycle aborts immediately, pins go inactive, DQ=Z; no rvalid/wdone is generated for the aborted op.

Decomposition:
- Package sram_ctrl_pkg holds:
  - typedef enum logic [1:0] {IDLE, READ, WRITE, WREC} sram_state_t
  - localparam SRAM_DATA_W=16, SRAM_ADDR_W=20
- One sub-module, sram_dq_tristate: registered wdata plus output-enable in, drives SRAM_DQ, returns bus value. It isolates the inout for synthesis.

Test Plan:
- Reset asserted → all five _N pins=1, SRAM_DQ=Z, ready=1, rvalid=0, wdone=0, rdata=0.
- WAIT_CYCLES=1, write addr=20'h00012 wdata=16'hBEEF be=11:
  - WE_N=0 for exactly 2 cycles with DQ=BEEF, then WREC.
  - wdone pulses 3 cycles after accept; model mem[0x12]=BEEF.
  - Read of 0x12 → rvalid 2 cycles after accept, rdata=16'hBEEF.
- Write 16'h1234 be=01 to 0x12 → mem=16'hBE34; read with be=10 → rdata=16'hBE00.
- req held high through a write → exactly one access.
  - ready=0 during WRITE/WREC; second access accepted in the wdone cycle.
  - OE_N never low while DQ is driven.
- Reset pulsed during the second WRITE cycle → WE_N/CE_N=1 and DQ=Z asynchronously; no wdone after release; ready=1.
- WAIT_CYCLES=0, reads to 0x00,0x01,0x02 with req held → one rvalid every 2 cycles, rdata matching the model contents in order.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types, widths and helpers for the asynchronous SRAM controller.
package sram_ctrl_pkg;

    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_ADDR_W = 20;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        WREC
    } sram_state_t;

    // Zero every byte lane that was not enabled for the access.
    function automatic logic [SRAM_DATA_W-1:0] mask_bytes(
        input logic [SRAM_DATA_W-1:0] data,
        input logic [1:0]             be
    );
        mask_bytes = {be[1] ? data[15:8] : 8'h00,
                      be[0] ? data[7:0]  : 8'h00};
    endfunction

endpackage

// File: rtl/sram_dq_tristate.sv
// Bidirectional SRAM data bus driver. Keeps the only tristate assignment in
// one place so the top level deals purely in unidirectional signals.
module sram_dq_tristate
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              oe,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] dq
);

    assign dq  = oe ? dout : {DATA_W{1'bz}};
    assign din = dq;

endmodule

// File: rtl/sram_ctrl.sv
// Initiator-side controller for an asynchronous 16-bit SRAM. Accepts one
// request at a time and sequences the active-low strobes with a fixed
// number of wait states. Every SRAM pin is driven straight from a flop.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        be,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wdone,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N
);

    // A zero-wait configuration still needs a one-bit counter.
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    sram_state_t        state;
    sram_state_t        next_state;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_done;
    logic               accept;
    logic [1:0]         be_q;
    logic [1:0]         be_next;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  din;
    logic               dq_oe;

    // Next values for the pin flops, decoded from the upcoming state.
    logic               ce_n_d;
    logic               ub_n_d;
    logic               lb_n_d;
    logic               oe_n_d;
    logic               we_n_d;
    logic               dq_oe_d;

    assign ready    = (state == IDLE);
    assign accept   = req & ready;
    assign cnt_done = (cnt == '0);

    // Byte enables for the pins must already reflect a request being accepted
    // this cycle, since the strobes go active on the same edge.
    assign be_next  = accept ? be : be_q;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: each access phase lasts until the wait counter hits zero.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = we ? WRITE : READ;
                end
            end
            READ: begin
                if (cnt_done) begin
                    next_state = IDLE;
                end
            end
            WRITE: begin
                if (cnt_done) begin
                    next_state = WREC;
                end
            end
            WREC: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Pin decode for the upcoming state; the bus driver stays on through
    // WREC so data is held while WE_N rises.
    always_comb begin
        ce_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (next_state)
            READ: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                ub_n_d = ~be_next[1];
                lb_n_d = ~be_next[0];
            end
            WRITE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                ub_n_d  = ~be_next[1];
                lb_n_d  = ~be_next[0];
                dq_oe_d = 1'b1;
            end
            WREC: begin
                dq_oe_d = 1'b1;
            end
            default: begin
                dq_oe_d = 1'b0;
            end
        endcase
    end

    // Pin flops: reset drops every strobe and releases the bus immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            SRAM_CE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
        end else begin
            SRAM_CE_N <= ce_n_d;
            SRAM_UB_N <= ub_n_d;
            SRAM_LB_N <= lb_n_d;
            SRAM_OE_N <= oe_n_d;
            SRAM_WE_N <= we_n_d;
            dq_oe     <= dq_oe_d;
        end
    end

    // Request capture and wait counter; the address only moves on accept.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt       <= '0;
            be_q      <= 2'b00;
            SRAM_ADDR <= '0;
        end else if (accept) begin
            cnt       <= CNT_W'(WAIT_CYCLES);
            be_q      <= be;
            SRAM_ADDR <= addr;
        end else if ((state == READ || state == WRITE) && !cnt_done) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Write data is only meaningful while the driver is enabled, so it needs no reset.
    always_ff @(posedge Clk) begin
        if (accept) begin
            wdata_q <= wdata;
        end
    end

    // Completion pulses and read capture on the last edge of the access.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rvalid <= 1'b0;
            wdone  <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= (state == READ) && cnt_done;
            wdone  <= (state == WREC);
            if ((state == READ) && cnt_done) begin
                rdata <= mask_bytes(din, be_q);
            end
        end
    end

    sram_dq_tristate #(
        .DATA_W (DATA_W)
    ) u_dq (
        .oe   (dq_oe),
        .dout (wdata_q),
        .din  (din),
        .dq   (SRAM_DQ)
    );

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: one instance with one wait state, one with none,
// each attached to a small behavioural SRAM with a pulled-up data bus.
module tb_sram_ctrl;

    localparam int W1 = 1;
    localparam int W0 = 0;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Instance with WAIT_CYCLES=1
    logic        req1 = 1'b0, we1 = 1'b0;
    logic [19:0] addr1 = '0;
    logic [15:0] wdata1 = '0;
    logic [1:0]  be1 = '0;
    logic        ready1, rvalid1, wdone1, ce1, ub1, lb1, oe1, wen1;
    logic [15:0] rdata1;
    logic [19:0] sa1;
    wire  [15:0] dq1;

    // Instance with WAIT_CYCLES=0
    logic        req0 = 1'b0, we0 = 1'b0;
    logic [19:0] addr0 = '0;
    logic [15:0] wdata0 = '0;
    logic [1:0]  be0 = '0;
    logic        ready0, rvalid0, wdone0, ce0, ub0, lb0, oe0, wen0;
    logic [15:0] rdata0;
    logic [19:0] sa0;
    wire  [15:0] dq0;

    sram_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(W1)) dut1 (
        .Clk(Clk), .Reset(Reset), .req(req1), .we(we1), .addr(addr1),
        .wdata(wdata1), .be(be1), .ready(ready1), .rdata(rdata1),
        .rvalid(rvalid1), .wdone(wdone1), .SRAM_ADDR(sa1), .SRAM_DQ(dq1),
        .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1),
        .SRAM_OE_N(oe1), .SRAM_WE_N(wen1)
    );

    sram_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(W0)) dut0 (
        .Clk(Clk), .Reset(Reset), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .be(be0), .ready(ready0), .rdata(rdata0),
        .rvalid(rvalid0), .wdone(wdone0), .SRAM_ADDR(sa0), .SRAM_DQ(dq0),
        .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0),
        .SRAM_OE_N(oe0), .SRAM_WE_N(wen0)
    );

    // Undriven bus reads as all ones.
    pullup (dq1);
    pullup (dq0);

    // Behavioural SRAMs (low 8 address bits decoded)
    logic [15:0] mem1 [0:255];
    logic [15:0] mem0 [0:255];

    assign dq1 = (!ce1 && !oe1 && wen1) ?
                 {ub1 ? 8'hzz : mem1[sa1[7:0]][15:8], lb1 ? 8'hzz : mem1[sa1[7:0]][7:0]} : 16'hzzzz;
    assign dq0 = (!ce0 && !oe0 && wen0) ?
                 {ub0 ? 8'hzz : mem0[sa0[7:0]][15:8], lb0 ? 8'hzz : mem0[sa0[7:0]][7:0]} : 16'hzzzz;

    always @(posedge Clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 16'h0000;
                mem0[i] <= 16'h0000;
            end
            mem1[8'h21] <= 16'hC3C3;
            mem0[8'h00] <= 16'h0F0F;
            mem0[8'h01] <= 16'hA0B1;
            mem0[8'h02] <= 16'h7E57;
        end else begin
            if (!ce1 && !wen1) begin
                if (!ub1) mem1[sa1[7:0]][15:8] <= dq1[15:8];
                if (!lb1) mem1[sa1[7:0]][7:0]  <= dq1[7:0];
            end
            if (!ce0 && !wen0) begin
                if (!ub0) mem0[sa0[7:0]][15:8] <= dq0[15:8];
                if (!lb0) mem0[sa0[7:0]][7:0]  <= dq0[7:0];
            end
        end
    end

    // Scoreboard state
    exp_t        q1[$];
    exp_t        q0[$];
    logic [19:0] cur_addr  [2];
    logic [15:0] cur_wdata [2];
    logic [1:0]  cur_be    [2];
    int          we_run    [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor: pops the scoreboard on completion pulses and checks pin protocol.
    task automatic mon(input int inst, input logic rv, input logic wd, input logic [15:0] rd,
                       input logic rdy, input logic [19:0] sa, input logic [15:0] dq,
                       input logic ce, input logic oe, input logic wen,
                       input logic ub, input logic lb);
        exp_t        e;
        logic [15:0] m;
        string       p;
        int          w;
        int          qs;
        p  = (inst == 1) ? "w1" : "w0";
        w  = (inst == 1) ? W1 : W0;
        qs = (inst == 1) ? q1.size() : q0.size();
        m  = (inst == 1) ? mem1[sa[7:0]] : mem0[sa[7:0]];
        if (Reset) begin
            we_run[inst] = 0;
            return;
        end
        if (rv || wd) begin
            if (qs == 0) begin
                tests++;
                fails++;
                $display("FAIL %s_unexpected_pulse: got rvalid=%b wdone=%b, required no pulse", p, rv, wd);
            end else begin
                if (inst == 1) e = q1.pop_front();
                else           e = q0.pop_front();
                chk({p, "_kind"}, {30'd0, rv, wd}, e.is_read ? 32'd2 : 32'd1);
                chk({p, "_latency"}, cyc, e.cyc);
                if (e.is_read) chk({p, "_rdata"}, {16'd0, rd}, {16'd0, e.data});
            end
        end
        if (!wen) begin
            chk({p, "_wr_oe_off"}, {31'd0, oe}, 32'd1);
            chk({p, "_wr_ce"}, {31'd0, ce}, 32'd0);
            chk({p, "_wr_ready"}, {31'd0, rdy}, 32'd0);
            chk({p, "_wr_addr"}, {12'd0, sa}, {12'd0, cur_addr[inst]});
            chk({p, "_wr_lanes"}, {30'd0, ub, lb}, {30'd0, ~cur_be[inst]});
            chk({p, "_wr_dq"}, {16'd0, dq}, {16'd0, cur_wdata[inst]});
        end
        if (!oe) begin
            chk({p, "_rd_ce"}, {31'd0, ce}, 32'd0);
            chk({p, "_rd_ready"}, {31'd0, rdy}, 32'd0);
            chk({p, "_rd_addr"}, {12'd0, sa}, {12'd0, cur_addr[inst]});
            chk({p, "_rd_lanes"}, {30'd0, ub, lb}, {30'd0, ~cur_be[inst]});
            chk({p, "_rd_dq"}, {16'd0, dq},
                {16'd0, ub ? 8'hFF : m[15:8], lb ? 8'hFF : m[7:0]});
        end
        if (oe && wen && (dq !== 16'hFFFF)) begin
            chk({p, "_hold_ready"}, {31'd0, rdy}, 32'd0);
            chk({p, "_hold_ce"}, {31'd0, ce}, 32'd1);
            chk({p, "_hold_dq"}, {16'd0, dq}, {16'd0, cur_wdata[inst]});
            chk({p, "_hold_addr"}, {12'd0, sa}, {12'd0, cur_addr[inst]});
        end
        if (rdy) begin
            chk({p, "_idle_pins"}, {27'd0, ce, oe, wen, ub, lb}, 32'h1F);
            chk({p, "_idle_dq"}, {16'd0, dq}, 32'h0000FFFF);
        end
        if (!wen) begin
            we_run[inst] = we_run[inst] + 1;
        end else if (we_run[inst] != 0) begin
            chk({p, "_we_len"}, we_run[inst], w + 1);
            we_run[inst] = 0;
        end
    endtask

    always @(negedge Clk) begin
        mon(1, rvalid1, wdone1, rdata1, ready1, sa1, dq1, ce1, oe1, wen1, ub1, lb1);
        mon(0, rvalid0, wdone0, rdata0, ready0, sa0, dq0, ce0, oe0, wen0, ub0, lb0);
    end

    // Quiescent-state check used after reset.
    task automatic quiet(input string p, input logic rdy, input logic rv, input logic wd,
                         input logic [15:0] rd, input logic [19:0] sa, input logic [15:0] dq,
                         input logic ce, input logic oe, input logic wen,
                         input logic ub, input logic lb);
        chk({p, "_rst_pins"}, {27'd0, ce, oe, wen, ub, lb}, 32'h1F);
        chk({p, "_rst_dq"}, {16'd0, dq}, 32'h0000FFFF);
        chk({p, "_rst_ready"}, {31'd0, rdy}, 32'd1);
        chk({p, "_rst_pulses"}, {30'd0, rv, wd}, 32'd0);
        chk({p, "_rst_rdata"}, {16'd0, rd}, 32'd0);
        chk({p, "_rst_addr"}, {12'd0, sa}, 32'd0);
    endtask

    // Drive one request starting at a negedge; returns the accept edge number.
    task automatic issue(input int inst, input bit w, input logic [19:0] a,
                         input logic [15:0] d, input logic [1:0] b,
                         input logic [15:0] exp_rd, input bit push, input bit hold,
                         output int acc);
        bit   ok;
        logic r;
        int   n;
        int   lat;
        exp_t e;
        ok  = 1'b0;
        acc = -1;
        n   = 0;
        if (inst == 1) begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = b;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
        end
        for (int i = 0; i < 40; i++) begin
            r = (inst == 1) ? ready1 : ready0;
            n = cyc;
            @(posedge Clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            acc             = n + 1;
            cur_addr[inst]  = a;
            cur_wdata[inst] = d;
            cur_be[inst]    = b;
            lat             = ((inst == 1) ? W1 : W0) + 1 + (w ? 1 : 0);
            if (push) begin
                e.is_read = !w;
                e.data    = exp_rd;
                e.cyc     = acc + lat;
                if (inst == 1) q1.push_back(e);
                else           q0.push_back(e);
            end
        end
        @(negedge Clk);
        if (!hold) begin
            if (inst == 1) req1 = 1'b0;
            else           req0 = 1'b0;
        end
    endtask

    task automatic drain(input int inst);
        int n;
        n = 0;
        while (((inst == 1) ? q1.size() : q0.size()) != 0 && n < 60) begin
            @(negedge Clk);
            n++;
        end
        chk((inst == 1) ? "w1_drain" : "w0_drain",
            (inst == 1) ? q1.size() : q0.size(), 32'd0);
        @(negedge Clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3, a4;
        we_run[0] = 0;
        we_run[1] = 0;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        quiet("w1", ready1, rvalid1, wdone1, rdata1, sa1, dq1, ce1, oe1, wen1, ub1, lb1);
        quiet("w0", ready0, rvalid0, wdone0, rdata0, sa0, dq0, ce0, oe0, wen0, ub0, lb0);
        Reset = 1'b0;
        @(negedge Clk);

        // One wait state: full-word write then read back
        issue(1, 1'b1, 20'h00012, 16'hBEEF, 2'b11, 16'h0000, 1'b1, 1'b0, a0); drain(1);
        issue(1, 1'b0, 20'h00012, 16'h0000, 2'b11, 16'hBEEF, 1'b1, 1'b0, a0); drain(1);
        // Lower-lane write, upper-lane read, full read
        issue(1, 1'b1, 20'h00012, 16'h1234, 2'b01, 16'h0000, 1'b1, 1'b0, a0); drain(1);
        issue(1, 1'b0, 20'h00012, 16'h0000, 2'b10, 16'hBE00, 1'b1, 1'b0, a0); drain(1);
        issue(1, 1'b0, 20'h00012, 16'h0000, 2'b11, 16'hBE34, 1'b1, 1'b0, a0); drain(1);

        // req held across back-to-back accesses, including be=00 accesses
        issue(1, 1'b1, 20'h00020, 16'hA5A5, 2'b11, 16'h0000, 1'b1, 1'b1, a0);
        issue(1, 1'b0, 20'h00020, 16'h0000, 2'b01, 16'h00A5, 1'b1, 1'b1, a1);
        issue(1, 1'b1, 20'h00021, 16'h5A5A, 2'b00, 16'h0000, 1'b1, 1'b1, a2);
        issue(1, 1'b0, 20'h00021, 16'h0000, 2'b11, 16'hC3C3, 1'b1, 1'b1, a3);
        issue(1, 1'b0, 20'h00021, 16'h0000, 2'b00, 16'h0000, 1'b1, 1'b0, a4);
        drain(1);
        chk("w1_b2b_wr_rd", a1 - a0, 32'd4);
        chk("w1_b2b_rd_wr", a2 - a1, 32'd3);
        chk("w1_b2b_wr0_rd", a3 - a2, 32'd4);
        chk("w1_b2b_rd_rd", a4 - a3, 32'd3);

        // Reset during the second WRITE cycle
        issue(1, 1'b1, 20'h00040, 16'h7777, 2'b11, 16'h0000, 1'b0, 1'b0, a0);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        quiet("w1_abort", ready1, rvalid1, wdone1, rdata1, sa1, dq1, ce1, oe1, wen1, ub1, lb1);
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        chk("w1_abort_ready", {31'd0, ready1}, 32'd1);
        issue(1, 1'b0, 20'h00012, 16'h0000, 2'b11, 16'hBE34, 1'b1, 1'b0, a0); drain(1);

        // No wait states: streamed reads with req held
        issue(0, 1'b0, 20'h00000, 16'h0000, 2'b11, 16'h0F0F, 1'b1, 1'b1, a0);
        issue(0, 1'b0, 20'h00001, 16'h0000, 2'b11, 16'hA0B1, 1'b1, 1'b1, a1);
        issue(0, 1'b0, 20'h00002, 16'h0000, 2'b11, 16'h7E57, 1'b1, 1'b0, a2);
        drain(0);
        chk("w0_stream_gap1", a1 - a0, 32'd2);
        chk("w0_stream_gap2", a2 - a1, 32'd2);
        issue(0, 1'b1, 20'h00003, 16'h9988, 2'b10, 16'h0000, 1'b1, 1'b0, a0); drain(0);
        issue(0, 1'b0, 20'h00003, 16'h0000, 2'b11, 16'h9900, 1'b1, 1'b0, a0); drain(0);

        repeat (4) @(negedge Clk);
        chk("w1_queue_empty", q1.size(), 32'd0);
        chk("w0_queue_empty", q0.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
